// File: rtl/alu_pkg.sv
// Shared ALU operation encodings used by the ALU, the datapath decoder and
// any block that borrows the ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b100,
    ALU_SLL = 3'b101
  } alu_ctrl_e;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier sequencer: produces the low XLEN bits of
// op_a*op_b by borrowing the shared single-cycle ALU for ADD and SLL steps.
module alu_mul_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MAX_ITER = 32,
  parameter int unsigned CNT_W    = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            alu_req,
  input  logic            alu_gnt,
  output logic [XLEN-1:0] alu_srca,
  output logic [XLEN-1:0] alu_srcb,
  output logic [2:0]      alu_ctrl,
  input  logic [XLEN-1:0] alu_result
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EVAL,
    S_ADD,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e          r_state;
  state_e          w_next;
  logic [XLEN-1:0] r_acc;
  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_mplier;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0] r_result;
  logic            w_finish;

  // Multiplication is complete once no multiplier bits remain or the
  // iteration cap has been reached.
  assign w_finish = (r_mplier == '0) || (r_cnt == CNT_W'(MAX_ITER));
  assign result   = r_result;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and ALU drive; ALU inputs are parked at zero/ADD
  // whenever the ALU is not being requested.
  always_comb begin
    w_next   = r_state;
    busy     = (r_state != S_IDLE);
    done     = (r_state == S_DONE);
    alu_req  = 1'b0;
    alu_srca = '0;
    alu_srcb = '0;
    alu_ctrl = ALU_ADD;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_EVAL;
      end
      S_EVAL: begin
        if (w_finish)        w_next = S_DONE;
        else if (r_mplier[0]) w_next = S_ADD;
        else                 w_next = S_SHIFT;
      end
      S_ADD: begin
        alu_req  = 1'b1;
        alu_srca = r_acc;
        alu_srcb = r_mcand;
        alu_ctrl = ALU_ADD;
        if (alu_gnt) w_next = S_SHIFT;
      end
      S_SHIFT: begin
        alu_req  = 1'b1;
        alu_srca = r_mcand;
        alu_srcb = XLEN'(1);
        alu_ctrl = ALU_SLL;
        if (alu_gnt) w_next = S_EVAL;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Operand/accumulator registers; ALU results are only taken on granted cycles.
  // result is captured on the EVAL->DONE transition (acc is already final
  // there) so it is valid in the same cycle done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc    <= '0;
            r_mcand  <= op_a;
            r_mplier <= op_b;
            r_cnt    <= '0;
          end
        end
        S_EVAL: begin
          if (w_finish) r_result <= r_acc;
        end
        S_ADD: begin
          if (alu_gnt) r_acc <= alu_result;
        end
        S_SHIFT: begin
          if (alu_gnt) begin
            r_mcand  <= alu_result;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Scoreboard bench for alu_mul_sequencer with a behavioural ALU and a
// product/latency reference model.
module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] result;
  logic        alu_req, alu_gnt;
  logic [31:0] alu_srca, alu_srcb, alu_result;
  logic [2:0]  alu_ctrl;

  alu_mul_sequencer #(.XLEN(32), .MAX_ITER(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result),
    .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_srca(alu_srca),
    .alu_srcb(alu_srcb), .alu_ctrl(alu_ctrl), .alu_result(alu_result)
  );

  always #5 clk = ~clk;

  // Behavioural shared ALU.
  always_comb begin
    case (alu_ctrl)
      3'b000:  alu_result = alu_srca + alu_srcb;
      3'b001:  alu_result = alu_srca - alu_srcb;
      3'b010:  alu_result = alu_srca & alu_srcb;
      3'b011:  alu_result = alu_srca | alu_srcb;
      3'b100:  alu_result = ($signed(alu_srca) < $signed(alu_srcb)) ? 32'd1 : 32'd0;
      3'b101:  alu_result = alu_srca << alu_srcb[4:0];
      default: alu_result = '0;
    endcase
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] prod;
    int          nom;
    int          acc_cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          gnt_mode = 0;
  int          denied = 0;
  bit          have_result = 0;
  logic [31:0] last_result;
  logic        prev_denied = 0;
  logic [31:0] prev_srca, prev_srcb;
  logic [2:0]  prev_ctrl;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycles from accepting edge to the edge that raises done, all grants given.
  function automatic int nominal(input logic [31:0] b);
    int msb;
    msb = -1;
    for (int i = 0; i < 32; i++) if (b[i]) msb = i;
    if (b == 0) return 2;
    return 2 + 2 * (msb + 1) + $countones(b);
  endfunction

  // Grant driver: always, random, or the repeating 1,0,0,1 pattern.
  initial begin
    int pat;
    pat = 0;
    alu_gnt = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (gnt_mode)
        0: alu_gnt = 1'b1;
        1: alu_gnt = 1'($urandom_range(0, 1));
        default: begin
          alu_gnt = (pat == 0) || (pat == 3);
          pat = (pat + 1) % 4;
        end
      endcase
    end
  end

  // Monitor: interface rules every cycle, scoreboard pop on done.
  always @(negedge clk) begin
    if (!rst_n) begin
      denied      = 0;
      have_result = 0;
      prev_denied = 0;
    end else begin
      if (!alu_req) begin
        chk("idle_srca", alu_srca, 32'd0);
        chk("idle_srcb", alu_srcb, 32'd0);
        chk("idle_ctrl", {29'd0, alu_ctrl}, 32'd0);
      end else begin
        chk("req_ctrl_legal", {31'd0, (alu_ctrl == 3'b000 || alu_ctrl == 3'b101)}, 32'd1);
        if (alu_ctrl == 3'b101) chk("sll_srcb", alu_srcb, 32'd1);
      end
      if (prev_denied) begin
        chk("frozen_srca", alu_srca, prev_srca);
        chk("frozen_srcb", alu_srcb, prev_srcb);
        chk("frozen_ctrl", {29'd0, alu_ctrl}, {29'd0, prev_ctrl});
        chk("frozen_req", {31'd0, alu_req}, 32'd1);
      end
      if (alu_req && !alu_gnt) denied++;
      prev_denied = alu_req && !alu_gnt;
      prev_srca   = alu_srca;
      prev_srcb   = alu_srcb;
      prev_ctrl   = alu_ctrl;

      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result", result, e.prod);
          chk("latency", 32'(cyc - e.acc_cyc + 1), 32'(e.nom + denied));
          chk("busy_at_done", {31'd0, busy}, 32'd1);
        end
        denied      = 0;
        have_result = 1;
        last_result = result;
      end else if (have_result) begin
        chk("result_hold", result, last_result);
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input bit extra_starts, input bit wait_done);
    int  guard;
    bit  idle;
    exp_t e;
    guard = 0;
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    do begin
      idle = !busy;
      @(posedge clk);
      #1;
      guard++;
    end while (!idle && guard < 400);
    if (!idle) begin
      chk("accept_timeout", 32'd0, 32'd1);
      start = 1'b0;
      return;
    end
    e.a = a; e.b = b; e.prod = a * b; e.nom = nominal(b); e.acc_cyc = cyc;
    sb.push_back(e);
    start = 1'b0;
    op_a  = $urandom;
    op_b  = $urandom;
    if (extra_starts) begin
      for (int k = 0; k < 2; k++) begin
        @(negedge clk);
        @(negedge clk);
        op_a  = $urandom;
        op_b  = $urandom;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    end
    if (wait_done) begin
      guard = 0;
      while ((sb.size() != 0 || busy) && guard < 400) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 400) chk("done_timeout", 32'd0, 32'd1);
    end
  endtask

  initial begin
    int guard;
    rst_n = 1'b0;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_req", {31'd0, alu_req}, 32'd0);
    chk("rst_srca", alu_srca, 32'd0);
    chk("rst_srcb", alu_srcb, 32'd0);
    chk("rst_ctrl", {29'd0, alu_ctrl}, 32'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    issue(32'd3, 32'd5, 0, 1);
    issue(32'h12345678, 32'd0, 0, 1);
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1);
    issue(32'd7, 32'hFFFFFFFE, 0, 1);
    gnt_mode = 2;
    issue(32'd6, 32'd7, 0, 1);
    gnt_mode = 0;
    issue(32'd11, 32'd13, 1, 1);

    // Reset in the middle of an operation.
    issue(32'h0000DEAD, 32'h000000FF, 0, 0);
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!(alu_req && alu_ctrl == 3'b101) && guard < 300);
    chk("reach_shift", {31'd0, alu_req && alu_ctrl == 3'b101}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_req", {31'd0, alu_req}, 32'd0);
    chk("midrst_result", result, 32'd0);
    sb.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    issue(32'd9, 32'd9, 0, 1);

    // Start held through done: next operation accepted once back in IDLE.
    issue(32'd100, 32'd3, 0, 0);
    issue(32'hABCDEF01, 32'h00000811, 0, 1);

    for (int i = 0; i < 30; i++) begin
      logic [31:0] a, b;
      gnt_mode = $urandom_range(0, 1);
      a = $urandom;
      b = $urandom;
      if (i % 3 == 0) b = b & 32'h000000FF;
      issue(a, b, (i % 7 == 0), (i % 4 != 0));
    end
    gnt_mode = 0;
    guard = 0;
    while ((sb.size() != 0 || busy) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) chk("drain_timeout", 32'd0, 32'd1);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
